// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter.
//   arb_state_t : arbiter FSM states
//   DEV_W/REG_W/DATA_W : device address, register address and data widths
//   gap_cnt_w() : width of the post-transaction gap counter
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        GAP
    } arb_state_t;

    localparam int unsigned DEV_W  = 8;
    localparam int unsigned REG_W  = 16;
    localparam int unsigned DATA_W = 8;

    // The gap counter only runs from 0 to gap_cycles-2, because the IDLE
    // arbitration cycle supplies the last idle cycle.
    function automatic int unsigned gap_cnt_w(input int unsigned gap_cycles);
        return (gap_cycles <= 3) ? 1 : $clog2(gap_cycles - 1);
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker.
//   pending    : per-requester request vector
//   last_grant : index of the previous winner; search starts one above it
//   winner     : one-hot winner (0 when nothing pending)
//   winner_idx : binary index of the winner
//   valid      : any request pending
module i2c_rr_pick #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = '0;
        // Walk last_grant+1 .. last_grant+NREQ (mod NREQ); first pending wins.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDX_W'((32'(last_grant) + k) % NREQ);
            if (!found && pending[idx]) begin
                winner[idx] = 1'b1;
                winner_idx  = idx;
                found       = 1'b1;
            end
        end
    end

    assign valid = |pending;

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master engine among NREQ requesters.
//   clk, rst            : clock, asynchronous active-high reset
//   req_wr/req_rd       : per-requester level requests, held until ack
//   req_addr_2byte, req_dev_addr, req_reg_addr, req_wdata : per-requester payload
//   ack, ack_err, rdata : completion pulse to the owner, error flag, read data
//   grant, busy         : one-hot current owner, FSM not idle
//   m_*                 : engine request/payload outputs and ack/data/error inputs
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_addr_2byte,
    input  logic [NREQ*8-1:0]    req_dev_addr,
    input  logic [NREQ*16-1:0]   req_reg_addr,
    input  logic [NREQ*8-1:0]    req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic                 ack_err,
    output logic [DATA_W-1:0]    rdata,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 m_write_req,
    output logic                 m_read_req,
    output logic                 m_addr_2byte,
    output logic [DEV_W-1:0]     m_dev_addr,
    output logic [REG_W-1:0]     m_reg_addr,
    output logic [DATA_W-1:0]    m_wdata,
    input  logic                 m_write_req_ack,
    input  logic                 m_read_req_ack,
    input  logic [DATA_W-1:0]    m_rdata,
    input  logic                 m_error
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned GAP_W = gap_cnt_w(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] last_grant;
    logic [GAP_W-1:0] gap_cnt;
    logic             is_wr;

    logic [NREQ-1:0]  pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             done;
    logic             gap_end;

    i2c_rr_pick #(.NREQ(NREQ)) u_pick (
        .pending    (req_wr | req_rd),
        .last_grant (last_grant),
        .winner     (pick),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // Only the ack matching the issued type completes the transaction.
    assign done    = (state == WAIT_ACK) && (is_wr ? m_write_req_ack : m_read_req_ack);
    assign gap_end = (gap_cnt == GAP_LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (pick_valid) state_n = ISSUE;
            ISSUE:    state_n = WAIT_ACK;
            WAIT_ACK: if (done) state_n = GAP;
            GAP:      if (gap_end) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant   <= IDX_W'(NREQ - 1);
            grant        <= '0;
            is_wr        <= 1'b0;
            gap_cnt      <= '0;
            ack          <= '0;
            ack_err      <= 1'b0;
            rdata        <= '0;
            m_write_req  <= 1'b0;
            m_read_req   <= 1'b0;
            m_addr_2byte <= 1'b0;
            m_dev_addr   <= '0;
            m_reg_addr   <= '0;
            m_wdata      <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant        <= pick;
                        last_grant   <= pick_idx;
                        is_wr        <= req_wr[pick_idx];
                        m_addr_2byte <= req_addr_2byte[pick_idx];
                        m_dev_addr   <= req_dev_addr[32'(pick_idx)*DEV_W +: DEV_W];
                        m_reg_addr   <= req_reg_addr[32'(pick_idx)*REG_W +: REG_W];
                        m_wdata      <= req_wdata[32'(pick_idx)*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    m_write_req <= is_wr;
                    m_read_req  <= !is_wr;
                end
                WAIT_ACK: begin
                    if (done) begin
                        m_write_req <= 1'b0;
                        m_read_req  <= 1'b0;
                        ack         <= grant;
                        ack_err     <= m_error;
                        if (!is_wr) rdata <= m_rdata;
                        grant       <= '0;
                        gap_cnt     <= '0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: directed table, hand-written
// round-robin/gap/reset sequences and a randomized run against a
// transaction-level reference model.
module tb_i2c_master_arbiter;

    localparam int N   = 3;
    localparam int GAP = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    req_wr = '0, req_rd = '0, req_addr_2byte = '0;
    logic [N*8-1:0]  req_dev_addr = '0, req_wdata = '0;
    logic [N*16-1:0] req_reg_addr = '0;
    logic [N-1:0]    ack, grant;
    logic            ack_err, busy;
    logic [7:0]      rdata;
    logic            m_write_req, m_read_req, m_addr_2byte;
    logic [7:0]      m_dev_addr, m_wdata;
    logic [15:0]     m_reg_addr;
    logic            m_write_req_ack = 1'b0, m_read_req_ack = 1'b0, m_error = 1'b0;
    logic [7:0]      m_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2c_master_arbiter #(.NREQ(N), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .req_wr(req_wr), .req_rd(req_rd), .req_addr_2byte(req_addr_2byte),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .ack(ack), .ack_err(ack_err), .rdata(rdata), .grant(grant), .busy(busy),
        .m_write_req(m_write_req), .m_read_req(m_read_req), .m_addr_2byte(m_addr_2byte),
        .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_wdata(m_wdata),
        .m_write_req_ack(m_write_req_ack), .m_read_req_ack(m_read_req_ack),
        .m_rdata(m_rdata), .m_error(m_error)
    );

    typedef struct {
        int         rq;
        bit         wr, rd, b2;
        logic [7:0] dev;
        logic [15:0] rg;
        logic [7:0] wd;
        logic [7:0] eng_rdata;
        bit         eng_err;
        logic [7:0] x_rdata;
        bit         x_err;
        bit         x_write;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit wr, input bit rd, input bit b2,
                           input logic [7:0] dv, input logic [15:0] rg, input logic [7:0] wd);
        req_wr[i]            = wr;
        req_rd[i]            = rd;
        req_addr_2byte[i]    = b2;
        req_dev_addr[i*8+:8] = dv;
        req_reg_addr[i*16+:16] = rg;
        req_wdata[i*8+:8]    = wd;
    endtask

    task automatic run_txn(input vec_t v);
        logic [N-1:0] oh;
        oh = N'(1) << v.rq;
        set_req(v.rq, v.wr, v.rd, v.b2, v.dev, v.rg, v.wd);
        tick;
        chk("txn_grant", grant, oh);
        chk("txn_busy", busy, 1);
        chk("txn_no_mreq_yet", {m_write_req, m_read_req}, 0);
        tick;
        chk("txn_mwr", m_write_req, v.x_write);
        chk("txn_mrd", m_read_req, !v.x_write);
        chk("txn_dev", m_dev_addr, v.dev);
        chk("txn_reg", m_reg_addr, v.rg);
        chk("txn_wdata", m_wdata, v.wd);
        chk("txn_2byte", m_addr_2byte, v.b2);
        if (v.x_write) m_read_req_ack = 1'b1; else m_write_req_ack = 1'b1;
        tick;
        m_read_req_ack = 1'b0; m_write_req_ack = 1'b0;
        chk("txn_wrong_ack_ignored", ack, 0);
        chk("txn_req_held", m_write_req | m_read_req, 1);
        if (v.x_write) m_write_req_ack = 1'b1; else m_read_req_ack = 1'b1;
        m_rdata = v.eng_rdata;
        m_error = v.eng_err;
        tick;
        m_read_req_ack = 1'b0; m_write_req_ack = 1'b0; m_error = 1'b0; m_rdata = 8'hC7;
        chk("txn_ack", ack, oh);
        chk("txn_ack_err", ack_err, v.x_err);
        chk("txn_rdata", rdata, v.x_rdata);
        chk("txn_mreq_dropped", {m_write_req, m_read_req}, 0);
        chk("txn_grant_cleared", grant, 0);
        req_wr[v.rq] = 1'b0;
        req_rd[v.rq] = 1'b0;
        tick;
        chk("txn_ack_one_cycle", ack, 0);
        repeat (GAP) tick;
        chk("txn_idle", busy, 0);
        chk("txn_rdata_held", rdata, v.x_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n, exp_w;
        bit got;

        vt[0] = '{0, 1, 0, 1, 8'h78, 16'h3008, 8'h82, 8'hEE, 0, 8'h00, 0, 1};
        vt[1] = '{1, 0, 1, 0, 8'h3C, 16'h0012, 8'h00, 8'h5A, 0, 8'h5A, 0, 0};
        vt[2] = '{2, 1, 0, 1, 8'h50, 16'h1234, 8'hA5, 8'h33, 1, 8'h5A, 1, 1};
        vt[3] = '{0, 0, 1, 1, 8'h51, 16'h00FF, 8'h00, 8'hC3, 0, 8'hC3, 0, 0};
        vt[4] = '{1, 1, 1, 0, 8'h20, 16'hABCD, 8'h11, 8'h77, 0, 8'hC3, 0, 1};
        vt[5] = '{2, 0, 1, 1, 8'h61, 16'h0201, 8'h00, 8'h9E, 1, 8'h9E, 1, 0};

        // Reset values
        repeat (3) tick;
        chk("rst_ack", ack, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mreq", {m_write_req, m_read_req}, 0);
        chk("rst_payload", {m_addr_2byte, m_dev_addr, m_reg_addr, m_wdata}, 0);
        rst = 1'b0;
        tick;

        // Directed table
        for (int i = 0; i < 6; i++) run_txn(vt[i]);

        // Round-robin with both requesters held, plus gap timing
        set_req(0, 1, 0, 1, 8'h10, 16'h0100, 8'hA0);
        set_req(1, 1, 0, 0, 8'h11, 16'h0011, 8'hA1);
        n = 0;
        for (int t = 0; t < 4; t++) begin
            exp_w = t % 2;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                tick;
                n++;
                chk("rr_single_mreq", m_write_req & m_read_req, 0);
                if (grant != '0) got = 1'b1;
            end
            chk("rr_grant_seen", got, 1);
            chk("rr_order", grant, N'(1) << exp_w);
            if (t > 0) chk("rr_gap_cycles", n, 17);
            got = 1'b0;
            for (int k = 0; k < 5 && !got; k++) begin
                tick;
                if (m_write_req) got = 1'b1;
            end
            chk("rr_mreq_seen", got, 1);
            chk("rr_dev", m_dev_addr, exp_w ? 8'h11 : 8'h10);
            m_write_req_ack = 1'b1;
            tick;
            m_write_req_ack = 1'b0;
            n = 1;
            chk("rr_ack", ack, N'(1) << exp_w);
            req_wr[exp_w] = 1'b0;
            tick;
            n = 2;
            req_wr[exp_w] = 1'b1;
        end
        req_wr = '0;
        repeat (GAP + 2) tick;

        // Reset in WAIT_ACK
        set_req(0, 0, 1, 1, 8'h42, 16'h4242, 8'h00);
        tick;
        tick;
        chk("rst_mid_pre_mreq", m_read_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_mreq", {m_write_req, m_read_req}, 0);
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_busy", busy, 0);
        set_req(1, 1, 0, 0, 8'h43, 16'h0043, 8'h55);
        repeat (2) begin
            tick;
            chk("rst_mid_no_ack", ack, 0);
        end
        rst = 1'b0;
        tick;
        chk("rst_mid_first_grant", grant, 3'b001);
        chk("rst_mid_no_ack_after", ack, 0);
        req_wr = '0; req_rd = '0;
        rst = 1'b1;
        tick;
        rst = 1'b0;

        // Randomized run against the transaction-level model
        begin
            int owner, last, ready, issue;
            bit own_wr, ack_prev, eng_act;
            int eng_cnt;
            logic [N-1:0] pend, exp_ack;
            logic [7:0] exp_rdata;
            bit exp_err, xmw, xmr;
            owner = -1; last = N - 1; ready = 0; issue = 0; own_wr = 0;
            eng_act = 0; eng_cnt = 0; exp_rdata = 8'h00; exp_err = 0;
            for (int c = 1; c <= 3000; c++) begin
                tick;
                // Inputs still hold the previous cycle's values here.
                pend = req_wr | req_rd;
                ack_prev = (owner >= 0) && (c - 1 >= issue) &&
                           (own_wr ? m_write_req_ack : m_read_req_ack);
                exp_ack = '0;
                if (ack_prev) begin
                    exp_ack = N'(1) << owner;
                    if (!own_wr) exp_rdata = m_rdata;
                    exp_err = m_error;
                    owner = -1;
                    ready = c - 1 + GAP;
                end
                if (owner < 0 && pend != '0 && c - 1 >= ready) begin
                    for (int k = 1; k <= N && owner < 0; k++)
                        if (pend[(last + k) % N]) owner = (last + k) % N;
                    last = owner;
                    own_wr = req_wr[owner];
                    issue = c + 1;
                end
                chk("rnd_grant", grant, (owner >= 0) ? (N'(1) << owner) : N'(0));
                chk("rnd_busy", busy, (owner >= 0) || (c < ready));
                chk("rnd_ack", ack, exp_ack);
                chk("rnd_rdata", rdata, exp_rdata);
                if (exp_ack != '0) chk("rnd_ack_err", ack_err, exp_err);
                xmw = (owner >= 0) && (c >= issue) && own_wr;
                xmr = (owner >= 0) && (c >= issue) && !own_wr;
                chk("rnd_mwr", m_write_req, xmw);
                chk("rnd_mrd", m_read_req, xmr);
                if (xmw || xmr) begin
                    chk("rnd_dev", m_dev_addr, req_dev_addr[owner*8+:8]);
                    chk("rnd_reg", m_reg_addr, req_reg_addr[owner*16+:16]);
                    chk("rnd_wdata", m_wdata, req_wdata[owner*8+:8]);
                    chk("rnd_2byte", m_addr_2byte, req_addr_2byte[owner]);
                end
                // Requesters
                for (int i = 0; i < N; i++) begin
                    if (exp_ack[i]) begin
                        req_wr[i] = 1'b0;
                        req_rd[i] = 1'b0;
                    end else if (!(req_wr[i] | req_rd[i]) && $urandom_range(0, 9) == 0) begin
                        int ty;
                        ty = $urandom_range(0, 2);
                        set_req(i, ty != 1, ty != 0, 1'($urandom), 8'($urandom),
                                16'($urandom), 8'($urandom));
                    end
                end
                // Engine
                m_write_req_ack = 1'b0;
                m_read_req_ack  = 1'b0;
                m_rdata = 8'($urandom);
                m_error = ($urandom_range(0, 3) == 0);
                if (!eng_act && (m_write_req || m_read_req)) begin
                    eng_act = 1'b1;
                    eng_cnt = $urandom_range(0, 4);
                end
                if (eng_act) begin
                    if (eng_cnt == 0) begin
                        if (m_write_req) m_write_req_ack = 1'b1; else m_read_req_ack = 1'b1;
                        eng_act = 1'b0;
                    end else begin
                        eng_cnt--;
                        if ($urandom_range(0, 3) == 0) begin
                            if (m_write_req) m_read_req_ack = 1'b1; else m_write_req_ack = 1'b1;
                        end
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Shares one I2C master engine (level request, one-cycle ack pulse) among NREQ independent requesters, e.g. the boot-time sensor LUT sequencer and a runtime register-access port. Round-robin grant, latches the winner's transaction, drives the engine and returns read data and error. Enforces a programmable idle gap between bus transactions. Sits between the requesters and the I2C master core.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- GAP_CYCLES, 16, idle clk cycles after each ack before the next grant (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_wr  in  NREQ  per-requester write request, level, held until ack
- req_rd  in  NREQ  per-requester read request, level, held until ack
- req_addr_2byte  in  NREQ  16-bit register address select
- req_dev_addr  in  NREQ*8  device address, slice i = [8i+7:8i]
- req_reg_addr  in  NREQ*16  register address, slice i
- req_wdata  in  NREQ*8  write data, slice i
- ack  out  NREQ  one-cycle completion pulse to granted requester
- ack_err  out  1  engine error flag, valid with ack
- rdata  out  8  read data, valid with ack, held until next ack
- grant  out  NREQ  one-hot current owner, 0 when idle
- busy  out  1  high outside IDLE
- m_write_req / m_read_req  out  1  engine requests
- m_addr_2byte  out  1; m_dev_addr  out  8; m_reg_addr  out  16; m_wdata  out  8
- m_write_req_ack / m_read_req_ack  in  1  engine completion pulses
- m_rdata  in  8; m_error  in  1

## Operation
- States: IDLE, ISSUE, WAIT_ACK, GAP.
- IDLE: pending[i] = req_wr[i] | req_rd[i]. If any pending: pick winner by round-robin starting at last_grant+1 (mod NREQ), latch its payload and type (write if req_wr set, else read; both set -> write), set grant, last_grant, go ISSUE.
- ISSUE: assert m_write_req or m_read_req (registered) with latched payload on m_*; go WAIT_ACK.
- WAIT_ACK: hold m_*_req and payload. On the ack matching the issued type: clear m_*_req, capture m_rdata (reads only) and m_error, pulse ack[grant] next cycle, go GAP. Ack of the other type: ignored.
- GAP: counter counts GAP_CYCLES, grant cleared on entry, then IDLE. Requests arriving during GAP wait.
- Requester rule: payload stable while req high; req deasserted by the edge after ack. GAP ≥2 guarantees no re-grant of a stale request.
- last_grant reset = NREQ-1, so requester 0 wins first.
- Reset mid-operation: all state cleared, m_*_req drop immediately; no ack for the aborted transaction. Engine shares rst.

## Timing
- Reset values: ack=0, ack_err=0, rdata=0, grant=0, busy=0, m_write_req=m_read_req=0, m_* payload=0, state IDLE, gap counter 0.
- Request seen high at edge T (IDLE) -> grant/busy at T+1, m_*_req at T+2.
- Engine ack high in cycle A -> m_*_req low and ack[g]/rdata/ack_err valid in cycle A+1 (ack exactly 1 cycle).
- Earliest next grant: cycle A+1+GAP_CYCLES.
- Only one m_*_req high at any time; grant one-hot or zero.

## Structure
- Package i2c_arb_pkg: state enum (IDLE, ISSUE, WAIT_ACK, GAP), DEV_W=8, REG_W=16, DATA_W=8, gap counter width function.
- Sub-module i2c_rr_pick: combinational round-robin picker (pending, last_grant -> one-hot winner, valid).
- Top holds FSM, payload latch, gap counter, ack/rdata regs.

## Test plan
- Single write, req 0 (dev 0x78, reg 0x3008, data 0x82): engine sees those values with m_write_req, one ack[0] pulse, ack_err=0.
- Read, req 1: engine returns m_rdata=0x5A -> rdata=0x5A with ack[1]; rdata holds afterwards.
- Req 0 and 1 raised simultaneously and re-raised after ack: grant order 0,1,0,1; never two m_*_req high.
- m_error=1 on ack -> ack_err=1 with that ack; next transaction ack_err=0.
- GAP_CYCLES=16: next grant exactly 17 cycles after engine ack with request pending throughout.
- rst asserted in WAIT_ACK: m_write_req, grant, busy low same cycle; no ack; after release req 0 granted first.
